// File: rtl/arb_pkg.sv
// Shared helpers for the matrix arbiter and its requester-side clients.
// Vector helpers take up to MAX_N bits; callers zero-extend narrower vectors.
package arb_pkg;

    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } client_state_t;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic onehot0(input logic [MAX_N-1:0] vec);
        logic [MAX_N-1:0] one;
        one = 1;
        return (vec & (vec - one)) == '0;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int enc_lsb(input logic [MAX_N-1:0] vec);
        int r;
        r = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_burst_mux.sv
// N:1 valid/data/last mux toward the shared sink and ready demux back to the
// owning source. Everything is gated off while en is low.
module arb_burst_mux #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int IW = 2
) (
    input  logic            en,
    input  logic [IW-1:0]   idx,
    input  logic [N-1:0]    s_valid,
    input  logic [N*DW-1:0] s_data,
    input  logic [N-1:0]    s_last,
    output logic [N-1:0]    s_ready,
    input  logic            m_ready,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    output logic            sel_last
);

    logic [N-1:0] sel;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        assign sel[gi]     = en && (idx == IW'(gi));
        assign s_ready[gi] = sel[gi] & m_ready;
    end

    always_comb begin
        m_valid  = 1'b0;
        m_data   = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel[k]) begin
                m_valid  = s_valid[k];
                m_data   = s_data[k*DW +: DW];
                sel_last = s_last[k];
            end
        end
    end

endmodule

// File: rtl/arb_burst_client.sv
// Requester-side client of the N-way matrix arbiter: locks the granted channel
// for one burst (or MAXBURST beats) and strobes upd on the tenure's final beat.
module arb_burst_client
    import arb_pkg::*;
#(
    parameter int  N        = 3,
    parameter int  DW       = 32,
    parameter int  MAXBURST = 16,
    localparam int IW       = id_width(N),
    localparam int CW       = $clog2(MAXBURST + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    s_valid,
    output logic [N-1:0]    s_ready,
    input  logic [N*DW-1:0] s_data,
    input  logic [N-1:0]    s_last,
    output logic [N-1:0]    req,
    input  logic [N-1:0]    gnt,
    output logic            upd,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_last,
    output logic [IW-1:0]   m_id,
    output logic            err
);

    client_state_t state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg;

    logic          lock;
    logic          sel_last;
    logic          cut;
    logic          hs;
    logic          tenure_end;
    logic          err_cond;
    logic [N-1:0]  own_mask;

    assign lock     = (state_reg == LOCK);
    assign own_mask = N'(1) << idx_reg;
    assign cut      = (cnt_reg == CW'(MAXBURST - 1));
    assign hs       = m_valid & m_ready;

    arb_burst_mux #(
        .N  (N),
        .DW (DW),
        .IW (IW)
    ) u_mux (
        .en       (lock),
        .idx      (idx_reg),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .sel_last (sel_last)
    );

    // Holding req at onehot(idx) keeps the arbiter's grant on the owner while
    // locked; upd must fire while that grant is still standing.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        req        = s_valid;
        m_last     = 1'b0;
        m_id       = '0;
        tenure_end = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|gnt) begin
                    idx_next   = IW'(enc_lsb(MAX_N'(gnt)));
                    cnt_next   = '0;
                    state_next = LOCK;
                end
            end
            LOCK: begin
                req        = own_mask;
                m_id       = idx_reg;
                m_last     = sel_last | cut;
                tenure_end = hs & m_last;
                if (tenure_end) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (hs) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign upd = tenure_end;

    assign err_cond = !onehot0(MAX_N'(gnt))
                    || ((gnt & ~req) != '0)
                    || (lock && (gnt != own_mask));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_reg | err_cond;
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_arb_burst_client.sv
// Two clients (MAXBURST 16 and 4) against a behavioural LRG arbiter, per-channel
// source queues and a transaction-level reference of the tenure rules.
module tb_arb_burst_client;

    localparam int N  = 3;
    localparam int DW = 32;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    s_valid [2];
    logic [N-1:0]    s_ready [2];
    logic [N*DW-1:0] s_data  [2];
    logic [N-1:0]    s_last  [2];
    logic [N-1:0]    req     [2];
    logic [N-1:0]    gnt     [2];
    logic            upd     [2];
    logic            m_valid [2];
    logic            m_ready [2];
    logic [DW-1:0]   m_data  [2];
    logic            m_last  [2];
    logic [1:0]      m_id    [2];
    logic            err     [2];

    arb_burst_client #(.N(N), .DW(DW), .MAXBURST(16)) u_a (
        .clk(clk), .rstn(rstn), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .s_last(s_last[0]), .req(req[0]), .gnt(gnt[0]),
        .upd(upd[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_data(m_data[0]), .m_last(m_last[0]), .m_id(m_id[0]), .err(err[0])
    );

    arb_burst_client #(.N(N), .DW(DW), .MAXBURST(4)) u_b (
        .clk(clk), .rstn(rstn), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .s_last(s_last[1]), .req(req[1]), .gnt(gnt[1]),
        .upd(upd[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_data(m_data[1]), .m_last(m_last[1]), .m_id(m_id[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    // Source queues indexed inst*N+ch; entry = {last, data}.
    logic [DW:0]  srcq [2*N][$];
    logic [N-1:0] hold [2];
    bit           gf_en  [2];
    logic [N-1:0] gf_val [2];

    // Reference state: owner -1 means no tenure in progress.
    int owner [2];
    int beats [2];
    bit err_m [2];
    int prio  [2][N];

    // Observations of the DUT outputs, judged by the scenario tasks.
    int          upd_ids  [2][$];
    logic [DW-1:0] upd_data [2][$];
    int          cut_at   [2][$];
    int          dut_acc  [2*N];
    int          dut_beats[2];
    int          pushed   [2];

    int n_checks;
    int n_errors;

    function automatic int mb_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic logic [N-1:0] arb_pick(input int i, input logic [N-1:0] r);
        for (int p = 0; p < N; p++) begin
            if (r[prio[i][p]]) return N'(1) << prio[i][p];
        end
        return '0;
    endfunction

    function automatic int lsb_of(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int k = N - 1; k >= 0; k--) if (v[k]) r = k;
        return r;
    endfunction

    task automatic push_burst(input int i, input int ch, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++) begin
            srcq[i*N+ch].push_back({(b == len - 1), base + DW'(b)});
            pushed[i]++;
        end
    endtask

    // One clock: drive at the negedge, compare at +1, advance the reference at
    // the posedge, return at the next negedge.
    task automatic run_cycle();
        logic [N-1:0] req_e [2];
        bit hs_e [2], last_e [2], upd_e [2], econd [2];
        int o, id, pos;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) begin
                int q;
                q = i*N + k;
                s_valid[i][k] = (srcq[q].size() > 0) && !hold[i][k];
                s_data[i][k*DW +: DW] = (srcq[q].size() > 0) ? srcq[q][0][DW-1:0] : DW'($urandom);
                s_last[i][k] = (srcq[q].size() > 0) ? srcq[q][0][DW] : 1'b0;
            end
            o = owner[i];
            req_e[i] = (o < 0) ? s_valid[i] : (N'(1) << o);
            gnt[i] = gf_en[i] ? gf_val[i] : arb_pick(i, req_e[i]);
            hs_e[i] = (o >= 0) && s_valid[i][o] && m_ready[i];
            last_e[i] = (o >= 0) && (s_last[i][o] || beats[i] == mb_of(i) - 1);
            upd_e[i] = hs_e[i] && last_e[i];
            econd[i] = ($countones(gnt[i]) > 1) || ((gnt[i] & ~req_e[i]) != '0)
                     || ((o >= 0) && (gnt[i] != req_e[i]));
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            o = owner[i];
            n_checks += 7;
            if (req[i] !== req_e[i]) begin
                n_errors++; $display("FAIL req inst=%0d got=%b want=%b", i, req[i], req_e[i]);
            end
            if (m_valid[i] !== ((o >= 0) ? s_valid[i][o] : 1'b0)) begin
                n_errors++; $display("FAIL m_valid inst=%0d got=%b owner=%0d", i, m_valid[i], o);
            end
            if (s_ready[i] !== (((o >= 0) && m_ready[i]) ? req_e[i] : '0)) begin
                n_errors++; $display("FAIL s_ready inst=%0d got=%b owner=%0d", i, s_ready[i], o);
            end
            if (upd[i] !== upd_e[i]) begin
                n_errors++; $display("FAIL upd inst=%0d got=%b want=%b", i, upd[i], upd_e[i]);
            end
            if (m_last[i] !== last_e[i]) begin
                n_errors++; $display("FAIL m_last inst=%0d got=%b want=%b", i, m_last[i], last_e[i]);
            end
            if (m_id[i] !== 2'((o >= 0) ? o : 0)) begin
                n_errors++; $display("FAIL m_id inst=%0d got=%0d owner=%0d", i, m_id[i], o);
            end
            if (err[i] !== err_m[i]) begin
                n_errors++; $display("FAIL err inst=%0d got=%b want=%b", i, err[i], err_m[i]);
            end
            if (o >= 0) begin
                n_checks++;
                if (m_data[i] !== s_data[i][o*DW +: DW]) begin
                    n_errors++; $display("FAIL m_data inst=%0d got=%h want=%h", i, m_data[i], s_data[i][o*DW +: DW]);
                end
            end
            id = int'(m_id[i]);
            if (m_valid[i] && m_ready[i] && id < N) begin
                dut_beats[i]++;
                dut_acc[i*N+id]++;
                if (m_last[i] && id == 2) cut_at[i].push_back(dut_acc[i*N+id]);
            end
            if (upd[i]) begin
                upd_ids[i].push_back(id);
                upd_data[i].push_back(m_data[i]);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            o = owner[i];
            if (o < 0) begin
                if (gnt[i] != '0) begin
                    owner[i] = lsb_of(gnt[i]);
                    beats[i] = 0;
                end
            end else if (hs_e[i]) begin
                $display("beat inst=%0d ch=%0d data=%h last=%b", i, o, srcq[i*N+o][0][DW-1:0], last_e[i]);
                void'(srcq[i*N+o].pop_front());
                if (upd_e[i]) begin
                    pos = 0;
                    for (int p = 0; p < N; p++) if (prio[i][p] == o) pos = p;
                    for (int p = pos; p < N - 1; p++) prio[i][p] = prio[i][p+1];
                    prio[i][N-1] = o;
                    owner[i] = -1;
                    beats[i] = 0;
                end else begin
                    beats[i]++;
                end
            end
            if (econd[i]) err_m[i] = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic bit all_idle();
        for (int q = 0; q < 2*N; q++) if (srcq[q].size() > 0) return 1'b0;
        return (owner[0] < 0) && (owner[1] < 0);
    endfunction

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (!all_idle() && c < budget) begin
            run_cycle();
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_errors++; $display("FAIL drain_timeout cycles=%0d budget=%0d", c, budget);
        end
    endtask

    // Asserts rstn at a negedge, checks the asynchronous reset outputs, and
    // releases it at the following negedge.
    task automatic apply_reset();
        rstn = 1'b0;
        gnt[0] = '0;
        gnt[1] = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks += 8;
            if (req[i] !== s_valid[i]) begin
                n_errors++; $display("FAIL rst_req inst=%0d got=%b want=%b", i, req[i], s_valid[i]);
            end
            if (m_valid[i] !== 1'b0) begin n_errors++; $display("FAIL rst_m_valid inst=%0d got=%b want=0", i, m_valid[i]); end
            if (upd[i] !== 1'b0) begin n_errors++; $display("FAIL rst_upd inst=%0d got=%b want=0", i, upd[i]); end
            if (s_ready[i] !== '0) begin n_errors++; $display("FAIL rst_s_ready inst=%0d got=%b want=0", i, s_ready[i]); end
            if (m_id[i] !== 2'd0) begin n_errors++; $display("FAIL rst_m_id inst=%0d got=%0d want=0", i, m_id[i]); end
            if (m_last[i] !== 1'b0) begin n_errors++; $display("FAIL rst_m_last inst=%0d got=%b want=0", i, m_last[i]); end
            if (m_data[i] !== '0) begin n_errors++; $display("FAIL rst_m_data inst=%0d got=%h want=0", i, m_data[i]); end
            if (err[i] !== 1'b0) begin n_errors++; $display("FAIL rst_err inst=%0d got=%b want=0", i, err[i]); end
            owner[i] = -1;
            beats[i] = 0;
            err_m[i] = 1'b0;
            hold[i]  = '0;
            gf_en[i] = 1'b0;
            for (int p = 0; p < N; p++) prio[i][p] = p;
            upd_ids[i].delete();
            upd_data[i].delete();
            cut_at[i].delete();
            dut_beats[i] = 0;
            pushed[i] = 0;
        end
        for (int q = 0; q < 2*N; q++) dut_acc[q] = 0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        for (int q = 0; q < 2*N; q++) srcq[q].delete();
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = '0;
            m_ready[i] = 1'b0;
        end
        apply_reset();
        run_cycle();
        for (int i = 0; i < 2; i++) push_burst(i, 0, 1, 32'h11);
        run_cycle();
        for (int i = 0; i < 2; i++) m_ready[i] = 1'b1;
        drain(50);
    endtask

    task automatic test_single_burst();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            push_burst(i, 1, 4, 32'hA0);
            m_ready[i] = 1'b1;
        end
        drain(50);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (upd_ids[i].size() != 1) begin
                n_errors++; $display("FAIL single_upd_count inst=%0d got=%0d want=1", i, upd_ids[i].size());
            end else begin
                n_checks += 2;
                if (upd_ids[i][0] != 1) begin
                    n_errors++; $display("FAIL single_upd_id inst=%0d got=%0d want=1", i, upd_ids[i][0]);
                end
                if (upd_data[i][0] !== 32'hA3) begin
                    n_errors++; $display("FAIL single_upd_data inst=%0d got=%h want=a3", i, upd_data[i][0]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 4; b++)
                for (int ch = 0; ch < N; ch++) push_burst(i, ch, 2, DW'(ch*256 + b*16));
            m_ready[i] = 1'b1;
        end
        drain(400);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (upd_ids[i].size() != 12) begin
                n_errors++; $display("FAIL rr_tenures inst=%0d got=%0d want=12", i, upd_ids[i].size());
            end else begin
                for (int j = 0; j < 12; j++) begin
                    n_checks++;
                    if (upd_ids[i][j] != j % 3) begin
                        n_errors++; $display("FAIL rr_order inst=%0d slot=%0d got=%0d want=%0d", i, j, upd_ids[i][j], j % 3);
                    end
                end
            end
        end
    endtask

    task automatic test_forced_cut();
        int exp_ids [9];
        int n2;
        exp_ids = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        apply_reset();
        push_burst(1, 2, 10, 32'hC0);
        for (int b = 0; b < 3; b++) begin
            push_burst(1, 0, 2, DW'(32'h100 + b*16));
            push_burst(1, 1, 2, DW'(32'h200 + b*16));
        end
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        drain(400);
        n_checks += 2;
        if (upd_ids[0].size() != 0) begin
            n_errors++; $display("FAIL cut_idle_inst got=%0d want=0", upd_ids[0].size());
        end
        if (upd_ids[1].size() != 9) begin
            n_errors++; $display("FAIL cut_tenures got=%0d want=9", upd_ids[1].size());
        end else begin
            n2 = 0;
            for (int j = 0; j < 9; j++) begin
                n_checks++;
                if (upd_ids[1][j] != exp_ids[j]) begin
                    n_errors++; $display("FAIL cut_order slot=%0d got=%0d want=%0d", j, upd_ids[1][j], exp_ids[j]);
                end
                if (upd_ids[1][j] == 2) n2++;
            end
            n_checks++;
            if (n2 != 3) begin
                n_errors++; $display("FAIL cut_upd_ch2 got=%0d want=3", n2);
            end
        end
        n_checks++;
        if (cut_at[1].size() != 3) begin
            n_errors++; $display("FAIL cut_last_count got=%0d want=3", cut_at[1].size());
        end else begin
            n_checks += 3;
            if (cut_at[1][0] != 4) begin n_errors++; $display("FAIL cut_last0 got=%0d want=4", cut_at[1][0]); end
            if (cut_at[1][1] != 8) begin n_errors++; $display("FAIL cut_last1 got=%0d want=8", cut_at[1][1]); end
            if (cut_at[1][2] != 10) begin n_errors++; $display("FAIL cut_last2 got=%0d want=10", cut_at[1][2]); end
        end
    endtask

    task automatic test_backpressure();
        bit pat [4];
        int c;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 4; b++)
                for (int ch = 0; ch < N; ch++)
                    push_burst(i, ch, $urandom_range(1, 6), DW'($urandom));
        c = 0;
        while (!all_idle() && c < 3000) begin
            for (int i = 0; i < 2; i++) begin
                m_ready[i] = (c < 400) ? pat[c % 4] : 1'($urandom_range(0, 1));
                hold[i] = N'($urandom) & N'($urandom);
                if (owner[i] >= 0) hold[i][owner[i]] = (c % 9 >= 7);
            end
            run_cycle();
            c++;
        end
        for (int i = 0; i < 2; i++) begin
            hold[i] = '0;
            n_checks++;
            if (dut_beats[i] != pushed[i]) begin
                n_errors++; $display("FAIL bp_beat_total inst=%0d got=%0d want=%0d", i, dut_beats[i], pushed[i]);
            end
        end
        n_checks++;
        if (c >= 3000) begin
            n_errors++; $display("FAIL bp_timeout cycles=%0d budget=3000", c);
        end
    endtask

    task automatic test_errors();
        apply_reset();
        push_burst(0, 0, 3, 32'hE0);
        m_ready[0] = 1'b0;
        m_ready[1] = 1'b0;
        gf_en[0]  = 1'b1;
        gf_val[0] = 3'b011;
        run_cycle();
        gf_val[0] = 3'b100;
        run_cycle();
        gf_en[0] = 1'b0;
        for (int k = 0; k < 3; k++) run_cycle();
        n_checks += 2;
        if (err[0] !== 1'b1) begin
            n_errors++; $display("FAIL err_sticky got=%b want=1", err[0]);
        end
        if (err[1] !== 1'b0) begin
            n_errors++; $display("FAIL err_clean_inst got=%b want=0", err[1]);
        end
        m_ready[0] = 1'b1;
        #1;
        apply_reset();
        push_burst(0, 0, 0, 32'h0);
        pushed[0] = 3;
        drain(50);
        n_checks++;
        if (dut_beats[0] != 3) begin
            n_errors++; $display("FAIL err_post_reset_beats got=%0d want=3", dut_beats[0]);
        end
    endtask

    initial begin
        clk  = 1'b0;
        rstn = 1'b0;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = '0;
            s_data[i]  = '0;
            s_last[i]  = '0;
            gnt[i]     = '0;
            m_ready[i] = 1'b0;
            hold[i]    = '0;
            gf_en[i]   = 1'b0;
            gf_val[i]  = '0;
            owner[i]   = -1;
            beats[i]   = 0;
            err_m[i]   = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_single_burst();
        test_round_robin();
        test_forced_cut();
        test_backpressure();
        test_errors();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arb_burst_client.md
Name: arb_burst_client

Overview:
- Requester-side companion to the team's N-way matrix arbiter: it drives the arbiter's req/upd inputs and consumes its gnt vector.
- It funnels N upstream valid/ready burst channels onto one shared downstream channel.
- It holds the granted channel for a whole burst (until last, or a forced cut at MAXBURST beats), then pulses upd so the arbiter updates its least-recently-granted priority.
- Sits between N DMA/stream sources and a single shared sink port.

Parameters:
N, 3, number of upstream channels; must match the arbiter's N
DW, 32, data width per beat
MAXBURST, 16, maximum beats per tenure before a forced release (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
s_valid  input  N  per-channel beat valid
s_ready  output  N  per-channel beat accept
s_data  input  N*DW  per-channel data, channel k at bits [k*DW +: DW]
s_last  input  N  per-channel end-of-burst marker
req  output  N  request vector to the arbiter
gnt  input  N  grant vector from the arbiter (combinational from req)
upd  output  1  one-cycle priority-update strobe to the arbiter
m_valid  output  1  shared downstream valid
m_ready  input  1  shared downstream ready
m_data  output  DW  shared downstream data
m_last  output  1  end of tenure (s_last or forced cut)
m_id  output  IW=max(1,$clog2(N))  index of the owning channel
err  output  1  sticky protocol-error flag

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, idx=0, cnt=0, err=0.
  - Outputs under reset: m_valid=0, s_ready=0, upd=0, m_id=0, m_last=0, m_data=0.
  - req follows s_valid combinationally, including during reset.
- States: IDLE, LOCK. idx (IW bits) is the latched owner; cnt ($clog2(MAXBURST+1) bits) counts accepted beats in the tenure.
- IDLE:
  - req=s_valid; m_valid=0; s_ready=0; upd=0.
  - If gnt!=0: idx<=encode(gnt), cnt<=0, go to LOCK at the next edge.
  - Arbitration latency is one cycle: the first beat can transfer no earlier than the cycle after grant.
- LOCK:
  - req=onehot(idx), so the arbiter keeps gnt=onehot(idx).
  - Mux outputs: m_valid=s_valid[idx], m_data=s_data[idx], m_id=idx.
  - Ready routing: s_ready[idx]=m_ready; all other s_ready bits are 0.
  - Beat accepted when hs=m_valid&m_ready; on hs, cnt<=cnt+1.
  - end=hs&(s_last[idx] | cnt==MAXBURST-1); m_last=s_last[idx] | (cnt==MAXBURST-1).
  - On end: upd=1 in that same cycle, combinational, while gnt still equals onehot(idx). Next state is IDLE and cnt<=0.
  - upd is 1 in no other cycle.
  - s_valid[idx] dropping mid-burst: stay in LOCK, m_valid=0, cnt holds, no upd. There is no timeout.
- A forced cut passes through IDLE. The channel re-requests and competes normally; after upd it is lowest priority.
- Back-to-back tenures: minimum 1 IDLE cycle between the end beat and the next tenure's first beat.
- err is set (sticky until reset) when any of these holds:
  - gnt is not onehot0;
  - gnt & ~req != 0;
  - in LOCK, gnt != onehot(idx).
- The block keeps operating normally after err is set. In IDLE with multi-hot gnt, idx takes the lowest set bit.
- MAXBURST=1 makes every beat a tenure end.
- Reset asserted mid-LOCK returns immediately to IDLE. No upd is issued and any in-flight beat is dropped.

Decomposition:
- Shared package arb_pkg:
  - function onehot0(vec) and function enc_lsb(vec) (lowest-set-bit index), both parameterised by width.
  - localparam helper for IW, shared with the arbiter's testbench.
- One sub-module, arb_burst_mux: combinational N:1 data/valid/last mux plus ready demux, driven by idx and an enable.
- FSM, counter and error logic stay in the top level.

Test Plan:
- Reset then IDLE: s_valid=3'b000, pulse rstn low → req=0, m_valid=0, upd=0, err=0. Raise s_valid=3'b001 → req=3'b001 in the same cycle.
- Single burst: N=3, MAXBURST=16, ch1 sends 4 beats (0xA0..0xA3, last on beat 4), m_ready=1, arbiter granting ch1 → m_id=1, data in order, upd high only on the 0xA3 cycle, back to IDLE the next cycle.
- Round robin under contention: all 3 channels hold 2-beat bursts continuously → grant order 0,1,2,0,… One upd per tenure, never two tenures overlapping.
- Forced cut: MAXBURST=4, ch2 streams 10 beats with last only on beat 10.
  - m_last asserts on beats 4 and 8.
  - upd fires three times.
  - ch2 is re-granted only after the other requesters' turns.
- Backpressure and stall: m_ready toggles 1,0,0,1 and s_valid[idx] drops for 2 cycles mid-burst → no beat lost or duplicated, cnt unchanged during stalls, non-owner s_ready stays 0.
- Error injection: force gnt=3'b011, then gnt=3'b100 while req=3'b001 → err=1 and stays 1 until rstn; reset mid-LOCK → IDLE, no upd.
